// File: rtl/serial_shift_unit_if.sv
// Operand/handshake bundle between the register-read stage and the
// multi-cycle shifter. Clock and reset are plain ports on the shifter itself.
interface serial_shift_unit_if;
  logic        start;
  logic        kill;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  ctrl_shift_op;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  // Issuing side (execute-stage control / testbench)
  modport master (
    output start, kill, rs1, rs2, ctrl_shift_op,
    input  ready, busy, done, rd
  );

  // Shifter side
  modport slave (
    input  start, kill, rs1, rs2, ctrl_shift_op,
    output ready, busy, done, rd
  );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit for a small RV32EC core. Shifts STEP bits per
// cycle from an accumulator and pulses done for one cycle when rd is valid.
// Optional build macro: SHIFT_FASTSTEP_EN -- while the remaining count is at
// least 8, a cycle shifts by 8 instead of STEP (same results, shorter latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; rd holds the last result
// S_SHIFT | shifting r_acc, r_count holds the remaining amount
// S_DONE  | one-cycle result pulse; a new start may be accepted here
module serial_shift_unit #(
  parameter int STEP = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  serial_shift_unit_if.slave if_bus
);

  // Only power-of-two steps up to a byte are supported by the datapath.
  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
    $error("serial_shift_unit: STEP must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] LP_STEP = 5'(STEP);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_acc;
  logic [4:0]  r_count;
  logic [1:0]  r_op;

  logic        w_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_accept;
  logic        w_trivial;
  logic [4:0]  w_step_shamt;
  logic [4:0]  w_shamt;
  logic [4:0]  w_count_left;
  logic [31:0] w_acc_shifted;
  logic        w_unused_rs2_hi;

  // Amounts are modulo 32; the upper operand bits are deliberately ignored.
  assign w_unused_rs2_hi = ^if_bus.rs2[31:5];

  // Kill dominates start, so a flushed request is never accepted.
  assign w_accept  = if_bus.start & w_ready & ~if_bus.kill;

  // Zero amount or the undefined op code finish without shifting.
  assign w_trivial = (if_bus.rs2[4:0] == 5'd0) | (if_bus.ctrl_shift_op == 2'b01);

  // Clamp to the remaining count so r_count never underflows.
  assign w_step_shamt = (r_count < LP_STEP) ? r_count : LP_STEP;

`ifdef SHIFT_FASTSTEP_EN
  // Byte-sized strides while at least 8 positions remain.
  assign w_shamt = (r_count >= 5'd8) ? 5'd8 : w_step_shamt;
`else
  assign w_shamt = w_step_shamt;
`endif

  assign w_count_left = r_count - w_shamt;

  // One shift stride of the accumulator according to the latched op.
  always_comb begin
    w_acc_shifted = r_acc;
    case (r_op)
      OP_SLL:  w_acc_shifted = r_acc << w_shamt;
      OP_SRL:  w_acc_shifted = r_acc >> w_shamt;
      OP_SRA:  w_acc_shifted = $unsigned($signed(r_acc) >>> w_shamt);
      default: w_acc_shifted = r_acc;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_trivial ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
        if (if_bus.kill) begin
          w_state_nxt = S_IDLE;
        end else if (w_count_left == 5'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_trivial ? S_DONE : S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, stride update while shifting; a kill in
  // S_SHIFT simply freezes the partial result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= 32'd0;
      r_count <= 5'd0;
      r_op    <= 2'b00;
    end else if (w_accept) begin
      r_acc   <= if_bus.rs1;
      r_count <= if_bus.rs2[4:0];
      r_op    <= if_bus.ctrl_shift_op;
    end else if (r_state == S_SHIFT && !if_bus.kill) begin
      r_acc   <= w_acc_shifted;
      r_count <= w_count_left;
    end
  end

  assign if_bus.ready = w_ready;
  assign if_bus.busy  = w_busy;
  assign if_bus.done  = w_done;
  assign if_bus.rd    = r_acc;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: one STEP=1 and one STEP=4 instance.
module tb_serial_shift_unit;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b10;
  localparam logic [1:0] SRA = 2'b11;
  localparam logic [1:0] UND = 2'b01;

`ifdef SHIFT_FASTSTEP_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  serial_shift_unit_if bus1 ();
  serial_shift_unit_if bus4 ();

  serial_shift_unit #(.STEP(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .if_bus(bus1));
  serial_shift_unit #(.STEP(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .if_bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic kl,
                       input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (sel == 4) begin
      bus4.start = st; bus4.kill = kl; bus4.ctrl_shift_op = op; bus4.rs1 = a; bus4.rs2 = b;
    end else begin
      bus1.start = st; bus1.kill = kl; bus1.ctrl_shift_op = op; bus1.rs1 = a; bus1.rs2 = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, return busy-cycle count, busy right after the accept edge,
  // and rd at the done cycle. Budget of 100 cycles.
  task automatic do_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int busy_cyc,
                       output logic first_busy, output logic [31:0] res);
    logic dn;
    logic bz;
    drive(sel, 1'b1, 1'b0, op, a, b);
    tick();
    drive(sel, 1'b0, 1'b0, op, a, b);
    first_busy = (sel == 4) ? bus4.busy : bus1.busy;
    busy_cyc = 0;
    dn = (sel == 4) ? bus4.done : bus1.done;
    while (!dn && busy_cyc < 100) begin
      bz = (sel == 4) ? bus4.busy : bus1.busy;
      if (bz) busy_cyc++;
      else busy_cyc = 200;
      tick();
      dn = (sel == 4) ? bus4.done : bus1.done;
    end
    res = (sel == 4) ? bus4.rd : bus1.rd;
  endtask

  initial begin
    int          bc;
    logic        fb;
    logic [31:0] res;
    logic        seen_done;

    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    drive(1, 1'b0, 1'b0, SLL, 32'd0, 32'd0);
    drive(4, 1'b0, 1'b0, SLL, 32'd0, 32'd0);
    #2;
    chk("rst_ready", {31'd0, bus1.ready}, 32'd1);
    chk("rst_busy",  {31'd0, bus1.busy},  32'd0);
    chk("rst_done",  {31'd0, bus1.done},  32'd0);
    chk("rst_rd",    bus1.rd,             32'd0);
    #10 rst_n = 1'b1;
    tick();

    // SLL 1 by 31, STEP=1
    do_op(1, SLL, 32'h1, 32'd31, bc, fb, res);
    chk("sll31_busy_cycles", bc, 32'd31);
    chk("sll31_rd", res, 32'h8000_0000);
    chk("sll31_done", {31'd0, bus1.done}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, bus1.done}, 32'd0);
    chk("rd_hold", bus1.rd, 32'h8000_0000);

    // Right shifts by 4
    do_op(1, SRA, 32'h8000_0000, 32'd4, bc, fb, res);
    chk("sra4_busy_cycles", bc, 32'd4);
    chk("sra4_rd", res, 32'hF800_0000);
    do_op(1, SRL, 32'h8000_0000, 32'd4, bc, fb, res);
    chk("srl4_rd", res, 32'h0800_0000);
    do_op(1, SRA, 32'h7FFF_FFF0, 32'd4, bc, fb, res);
    chk("sra4_pos_rd", res, 32'h07FF_FFFF);
    do_op(4, SRA, 32'h8000_0000, 32'd4, bc, fb, res);
    chk("s4_sra4_busy_cycles", bc, 32'd1);
    chk("s4_sra4_rd", res, 32'hF800_0000);
    do_op(4, SLL, 32'h1, 32'd31, bc, fb, res);
    chk("s4_sll31_busy_cycles", bc, FAST ? 32'd5 : 32'd8);
    chk("s4_sll31_rd", res, 32'h8000_0000);

    // Zero, modulo and undefined-op cases
    do_op(1, SLL, 32'hDEAD_BEEF, 32'h20, bc, fb, res);
    chk("zero_busy_cycles", bc, 32'd0);
    chk("zero_first_busy", {31'd0, fb}, 32'd0);
    chk("zero_rd", res, 32'hDEAD_BEEF);
    do_op(1, SLL, 32'h3, 32'h25, bc, fb, res);
    chk("mod5_busy_cycles", bc, 32'd5);
    chk("mod5_rd", res, 32'h60);
    do_op(1, UND, 32'h1234, 32'd7, bc, fb, res);
    chk("undef_busy_cycles", bc, 32'd0);
    chk("undef_rd", res, 32'h1234);

    // Ignored start while busy, then kill mid-shift
    drive(1, 1'b1, 1'b0, SRL, 32'hFFFF_FFFF, 32'd10);
    tick();                                            // cycle 1
    drive(1, 1'b0, 1'b0, SRL, 32'hFFFF_FFFF, 32'd10);
    tick();                                            // cycle 2
    tick();                                            // cycle 3
    drive(1, 1'b1, 1'b0, SLL, 32'h1, 32'd2);
    tick();                                            // cycle 4
    chk("start_ignored_busy", {31'd0, bus1.busy}, 32'd1);
    chk("start_ignored_rd", bus1.rd, 32'h1FFF_FFFF);
    drive(1, 1'b0, 1'b0, SLL, 32'h1, 32'd2);
    tick();                                            // cycle 5
    drive(1, 1'b0, 1'b1, SLL, 32'h1, 32'd2);
    tick();
    drive(1, 1'b0, 1'b0, SLL, 32'h1, 32'd2);
    chk("kill_ready", {31'd0, bus1.ready}, 32'd1);
    chk("kill_busy",  {31'd0, bus1.busy},  32'd0);
    seen_done = bus1.done;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_done = seen_done | bus1.done;
    end
    chk("kill_no_done", {31'd0, seen_done}, 32'd0);
    do_op(1, SLL, 32'h1, 32'd2, bc, fb, res);
    chk("after_kill_busy_cycles", bc, 32'd2);
    chk("after_kill_rd", res, 32'h4);
    tick();

    // Start together with kill in idle: nothing accepted
    drive(1, 1'b1, 1'b1, SLL, 32'h55, 32'd3);
    tick();
    drive(1, 1'b0, 1'b0, SLL, 32'h55, 32'd3);
    chk("start_kill_busy", {31'd0, bus1.busy}, 32'd0);
    chk("start_kill_rd", bus1.rd, 32'h4);
    tick();
    chk("start_kill_no_done", {31'd0, bus1.done}, 32'd0);

    // Kill during the done cycle: pulse already out, next state idle
    do_op(1, SRL, 32'h100, 32'd1, bc, fb, res);
    chk("srl1_rd", res, 32'h80);
    chk("kill_in_done_pulse", {31'd0, bus1.done}, 32'd1);
    drive(1, 1'b1, 1'b1, SLL, 32'h1, 32'd3);
    tick();
    drive(1, 1'b0, 1'b0, SLL, 32'h1, 32'd3);
    chk("kill_in_done_next", {30'd0, bus1.busy, bus1.done}, 32'd0);
    chk("kill_in_done_rd", bus1.rd, 32'h80);

    // Asynchronous reset in the middle of a shift
    drive(1, 1'b1, 1'b0, SLL, 32'h1, 32'd31);
    tick();
    drive(1, 1'b0, 1'b0, SLL, 32'h1, 32'd31);
    tick();
    tick();
    chk("pre_reset_busy", {31'd0, bus1.busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy",  {31'd0, bus1.busy},  32'd0);
    chk("async_rst_done",  {31'd0, bus1.done},  32'd0);
    chk("async_rst_rd",    bus1.rd,             32'd0);
    chk("async_rst_ready", {31'd0, bus1.ready}, 32'd1);
    #2 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_done = seen_done | bus1.done | bus1.busy;
    end
    chk("post_rst_idle", {31'd0, seen_done}, 32'd0);
    chk("post_rst_ready", {31'd0, bus1.ready}, 32'd1);

    // Long shift, then back-to-back start in its done cycle
    do_op(1, SLL, 32'h1, 32'd20, bc, fb, res);
    chk("sll20_busy_cycles", bc, FAST ? 32'd6 : 32'd20);
    chk("sll20_rd", res, 32'h0010_0000);
    do_op(1, SRA, 32'h8000_0000, 32'd4, bc, fb, res);
    chk("b2b_no_bubble", {31'd0, fb}, 32'd1);
    chk("b2b_busy_cycles", bc, 32'd4);
    chk("b2b_rd", res, 32'hF800_0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
